// File: rtl/debug_frame_rx_if.sv
// Byte-in / frame-out bundle for debug_frame_rx.
// The UART side carries rx_ready, r_data and rd_uart. The consumer side carries
// frame_data, frame_valid and frame_error.
// master: the UART plus the frame consumer (the environment).
// slave:  the frame receiver.
interface debug_frame_rx_if #(
  parameter int FRAME_BYTES = 8
);
  logic                     rx_ready;
  logic [7:0]               r_data;
  logic                     rd_uart;
  logic [8*FRAME_BYTES-1:0] frame_data;
  logic                     frame_valid;
  logic                     frame_error;

  modport master (
    output rx_ready, r_data,
    input  rd_uart, frame_data, frame_valid, frame_error
  );

  modport slave (
    input  rx_ready, r_data,
    output rd_uart, frame_data, frame_valid, frame_error
  );
endinterface

// File: rtl/debug_frame_rx.sv
// Reassembles bytes popped from the UART receive buffer into one wide frame.
// The first byte received ends up in the MSBs of the frame.
// A partial frame is dropped, with a frame_error pulse, when the line stays idle
// too long. A partial frame is dropped silently when enable falls.
module debug_frame_rx #(
  parameter int FRAME_BYTES    = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  debug_frame_rx_if.slave       bus,
  output logic [7:0]            byte_count,
  output logic [1:0]            rx_state
);

  localparam int              W        = 8 * FRAME_BYTES;
  localparam int              CW       = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0]   TMO_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]      FB_LAST  = 8'(FRAME_BYTES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACK  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state, state_next;
  logic [W-1:0]  shift_reg;
  logic [W-1:0]  frame_reg;
  logic [CW-1:0] tmo_cnt;
  logic          rd_q;
  logic          valid_q;
  logic          error_q;

  logic          accept;      // take r_data this cycle
  logic          load_frame;  // last byte collected, publish shift_reg
  logic          tmo_count;   // idle inside a partial frame
  logic          tmo_hit;     // idle limit reached, drop partial frame
  logic          frame_done;  // DONE cycle, raise frame_valid next

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state and control decode.
  always_comb begin
    // NOTE: every signal gets a default here so no path through the case can
    // leave one unassigned and infer a latch.
    state_next = state;
    accept     = 1'b0;
    load_frame = 1'b0;
    tmo_count  = 1'b0;
    tmo_hit    = 1'b0;
    frame_done = 1'b0;
    unique case (state)
      IDLE: begin
        if (enable) begin
          if (bus.rx_ready) begin
            // A waiting byte beats an expiring timeout.
            accept     = 1'b1;
            state_next = ACK;
          end else if (byte_count != 8'd0) begin
            if (tmo_cnt == TMO_LAST) tmo_hit   = 1'b1;
            else                     tmo_count = 1'b1;
          end
        end
      end
      ACK: begin
        // rx_ready is ignored here while the UART retires the popped byte.
        if (byte_count == FB_LAST) begin
          load_frame = 1'b1;
          state_next = DONE;
        end else begin
          state_next = IDLE;
        end
      end
      DONE: begin
        frame_done = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    // Disabling aborts everything except a frame_valid pulse already owed.
    if (!enable) begin
      state_next = IDLE;
      load_frame = 1'b0;
    end
  end

  // Datapath: shift register, byte counter, idle timer and output pulses.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      shift_reg  <= '0;
      frame_reg  <= '0;
      tmo_cnt    <= '0;
      byte_count <= 8'd0;
      rd_q       <= 1'b0;
      valid_q    <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register sees the pre-edge
      // value of the others, independent of statement order.
      rd_q    <= accept;
      valid_q <= frame_done;
      error_q <= tmo_hit;
      if (!enable) begin
        shift_reg  <= '0;
        byte_count <= 8'd0;
        tmo_cnt    <= '0;
      end else if (accept) begin
        shift_reg  <= (shift_reg << 8) | W'(bus.r_data);
        byte_count <= byte_count + 8'd1;
        tmo_cnt    <= '0;
      end else if (load_frame) begin
        frame_reg  <= shift_reg;
        byte_count <= 8'd0;
      end else if (tmo_hit) begin
        shift_reg  <= '0;
        byte_count <= 8'd0;
        tmo_cnt    <= '0;
      end else if (tmo_count) begin
        tmo_cnt    <= tmo_cnt + CW'(1);
      end
    end
  end

  // The pop strobe is gated by enable so nothing is popped while disabled.
  assign bus.rd_uart     = rd_q & enable;
  assign bus.frame_data  = frame_reg;
  assign bus.frame_valid = valid_q;
  assign bus.frame_error = error_q;
  assign rx_state        = state;

endmodule
